// File: rtl/instr_mem_pipe.sv
// Writable instruction memory with a registered read pipeline of READ_LAT stages,
// a valid/ready fetch handshake, and a RUN/DRAIN/LOAD controller for run-time loading.
module instr_mem_pipe #(
  parameter int unsigned ADDR_BITS = 7,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_instr,
  output logic                 rsp_err,
  input  logic                 ld_en,
  input  logic                 ld_we,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
  state_t state;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [READ_LAT-1:0] stg_valid;
  logic [READ_LAT-1:0] stg_err;
  logic [DATA_W-1:0]   stg_instr [READ_LAT];

  logic                 advance;
  logic                 accept;
  logic                 out_of_range;
  logic                 misaligned;
  logic                 fetch_err;
  logic [ADDR_BITS-1:0] word_idx;
  logic [DATA_W-1:0]    fetch_word;

  assign advance      = !stg_valid[READ_LAT-1] || rsp_ready;
  assign req_ready    = (state == RUN) && advance && !ld_en;
  assign accept       = req_valid && req_ready;
  assign word_idx     = req_addr[ADDR_BITS+1:2];
  assign out_of_range = (req_addr >> (ADDR_BITS + 2)) != 32'd0;
  assign misaligned   = req_addr[1:0] != 2'b00;
  assign fetch_err    = out_of_range || misaligned;
  assign fetch_word   = fetch_err ? DEFAULT_WORD : mem[word_idx];

  assign rsp_valid = stg_valid[READ_LAT-1];
  assign rsp_instr = stg_instr[READ_LAT-1];
  assign rsp_err   = stg_err[READ_LAT-1];

  // Contents are deliberately not reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Whole pipeline shifts together; a stalled last stage freezes every stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_valid <= '0;
      stg_err   <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        stg_instr[i] <= DEFAULT_WORD;
      end
    end else if (advance) begin
      stg_valid[0] <= accept;
      stg_err[0]   <= accept && fetch_err;
      stg_instr[0] <= accept ? fetch_word : DEFAULT_WORD;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_err[i]   <= stg_err[i-1];
        stg_instr[i] <= stg_instr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ld_en) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!ld_en) begin
            state <= RUN;
            busy  <= 1'b0;
          end else if (stg_valid == '0) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (!ld_en) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench: one instance with READ_LAT=1 and one with READ_LAT=2 share all inputs.
module tb_instr_mem_pipe;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic        ld_we;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;

  logic        r1_req_ready, r1_rsp_valid, r1_rsp_err, r1_busy;
  logic [31:0] r1_rsp_instr;
  logic        r2_req_ready, r2_rsp_valid, r2_rsp_err, r2_busy;
  logic [31:0] r2_rsp_instr;

  int errors = 0;
  int checks = 0;
  logic [31:0] words [4];

  instr_mem_pipe #(.ADDR_BITS(7), .DATA_W(32), .READ_LAT(1), .DEFAULT_WORD(32'h8000_0000)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1_req_ready),
    .req_addr(req_addr), .rsp_valid(r1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(r1_rsp_instr), .rsp_err(r1_rsp_err), .ld_en(ld_en), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .busy(r1_busy));

  instr_mem_pipe #(.ADDR_BITS(7), .DATA_W(32), .READ_LAT(2), .DEFAULT_WORD(32'h8000_0000)) u2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r2_req_ready),
    .req_addr(req_addr), .rsp_valid(r2_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(r2_rsp_instr), .rsp_err(r2_rsp_err), .ld_en(ld_en), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .busy(r2_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    #2 reset = 1'b0;
    tick; tick;
    checks++; if (r1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %b expected 0", r1_rsp_valid); end
    checks++; if (r1_rsp_instr !== 32'h8000_0000) begin errors++; $display("FAIL rst_instr1: got %h expected 80000000", r1_rsp_instr); end
    checks++; if (r1_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err1: got %b expected 0", r1_rsp_err); end
    checks++; if (r1_busy !== 1'b0) begin errors++; $display("FAIL rst_busy1: got %b expected 0", r1_busy); end
    checks++; if (r2_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid2: got %b expected 0", r2_rsp_valid); end
    checks++; if (r2_rsp_instr !== 32'h8000_0000) begin errors++; $display("FAIL rst_instr2: got %h expected 80000000", r2_rsp_instr); end
    reset = 1'b1;
    tick;
    checks++; if (r1_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b expected 1", r1_req_ready); end
    checks++; if (r2_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready2: got %b expected 1", r2_req_ready); end
  endtask

  task automatic test_load_program;
    ld_en = 1'b1;
    tick;  // RUN -> DRAIN
    tick;  // DRAIN (empty) -> LOAD
    checks++; if (r1_busy !== 1'b1) begin errors++; $display("FAIL load_busy1: got %b expected 1", r1_busy); end
    checks++; if (r1_req_ready !== 1'b0) begin errors++; $display("FAIL load_ready1: got %b expected 0", r1_req_ready); end
    for (int i = 0; i < 4; i++) begin
      ld_we = 1'b1; ld_addr = 7'(i); ld_data = words[i];
      if (i == 3) ld_en = 1'b0;
      tick;
    end
    ld_we = 1'b0;
    checks++; if (r1_busy !== 1'b0) begin errors++; $display("FAIL load_exit_busy1: got %b expected 0", r1_busy); end
    tick;
  endtask

  task automatic test_fetch_lat1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      #1;
      checks++; if (r1_req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready%0d: got %b expected 1", i, r1_req_ready); end
      tick;
      checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_err !== 1'b0) begin errors++; $display("FAIL fetch_valid%0d: got v=%b e=%b expected v=1 e=0", i, r1_rsp_valid, r1_rsp_err); end
      checks++; if (r1_rsp_instr !== words[i]) begin errors++; $display("FAIL fetch_instr%0d: got %h expected %h", i, r1_rsp_instr, words[i]); end
    end
    req_valid = 1'b0;
    tick;
    checks++; if (r1_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle1: got %b expected 0", r1_rsp_valid); end
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[3]) begin errors++; $display("FAIL fetch_lat2_last: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[3]); end
    tick;
  endtask

  task automatic test_errors;
    req_valid = 1'b1; req_addr = 32'h200;
    tick;
    checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_err !== 1'b1 || r1_rsp_instr !== 32'h8000_0000) begin errors++; $display("FAIL err_range: got v=%b e=%b %h expected v=1 e=1 80000000", r1_rsp_valid, r1_rsp_err, r1_rsp_instr); end
    req_addr = 32'h6;
    tick;
    checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_err !== 1'b1 || r1_rsp_instr !== 32'h8000_0000) begin errors++; $display("FAIL err_align: got v=%b e=%b %h expected v=1 e=1 80000000", r1_rsp_valid, r1_rsp_err, r1_rsp_instr); end
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_err !== 1'b1 || r2_rsp_instr !== 32'h8000_0000) begin errors++; $display("FAIL err_range2: got v=%b e=%b %h expected v=1 e=1 80000000", r2_rsp_valid, r2_rsp_err, r2_rsp_instr); end
    req_valid = 1'b0;
    tick; tick;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    checks++; if (r2_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", r2_req_ready); end
    tick;
    req_addr = 32'h4;
    #1;
    checks++; if (r2_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b expected 1", r2_req_ready); end
    tick;
    req_addr = 32'h8;
    #1;
    checks++; if (r2_req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", r2_req_ready); end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[0] || r2_req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h rdy=%b expected v=1 %h rdy=0", k, r2_rsp_valid, r2_rsp_instr, r2_req_ready, words[0]); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (r2_req_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready: got %b expected 1", r2_req_ready); end
    tick;
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[1]) begin errors++; $display("FAIL bp_out1: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[1]); end
    req_addr = 32'hC;
    tick;
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[2]) begin errors++; $display("FAIL bp_out2: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[2]); end
    req_valid = 1'b0;
    tick;
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[3]) begin errors++; $display("FAIL bp_out3: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[3]); end
    tick;
    checks++; if (r2_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", r2_rsp_valid); end
    tick;
  endtask

  task automatic test_drain_load;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick;
    req_addr = 32'h4;
    tick;
    req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b1;
    #1;
    checks++; if (r2_busy !== 1'b0) begin errors++; $display("FAIL drain_busy_pre: got %b expected 0", r2_busy); end
    tick;
    checks++; if (r2_busy !== 1'b1 || r2_req_ready !== 1'b0) begin errors++; $display("FAIL drain_busy: got busy=%b rdy=%b expected busy=1 rdy=0", r2_busy, r2_req_ready); end
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[0]) begin errors++; $display("FAIL drain_rsp0: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[0]); end
    rsp_ready = 1'b1;
    tick;
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[1]) begin errors++; $display("FAIL drain_rsp1: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[1]); end
    tick;
    checks++; if (r2_rsp_valid !== 1'b0 || r2_busy !== 1'b1) begin errors++; $display("FAIL drain_done: got v=%b busy=%b expected v=0 busy=1", r2_rsp_valid, r2_busy); end
    tick;  // both instances now in LOAD
    ld_we = 1'b1; ld_addr = 7'd5; ld_data = 32'hDEAD_BEEF; ld_en = 1'b0;
    tick;
    ld_we = 1'b0;
    checks++; if (r1_busy !== 1'b0 || r2_busy !== 1'b0) begin errors++; $display("FAIL load_exit: got busy1=%b busy2=%b expected 0 0", r1_busy, r2_busy); end
    tick;
    req_valid = 1'b1; req_addr = 32'h14;
    tick;
    req_valid = 1'b0;
    checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL loaded_word1: got v=%b %h expected v=1 deadbeef", r1_rsp_valid, r1_rsp_instr); end
    tick;
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL loaded_word2: got v=%b %h expected v=1 deadbeef", r2_rsp_valid, r2_rsp_instr); end
    tick;
  endtask

  task automatic test_we_in_run;
    ld_en = 1'b0; ld_we = 1'b1; ld_addr = 7'd0; ld_data = 32'hFFFF_FFFF;
    tick; tick;
    ld_we = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    tick;
    req_valid = 1'b0;
    checks++; if (r1_rsp_instr !== words[0]) begin errors++; $display("FAIL we_run1: got %h expected %h", r1_rsp_instr, words[0]); end
    tick;
    checks++; if (r2_rsp_instr !== words[0]) begin errors++; $display("FAIL we_run2: got %h expected %h", r2_rsp_instr, words[0]); end
    tick;
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    tick; tick;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (r1_rsp_valid !== 1'b0 || r1_rsp_instr !== 32'h8000_0000 || r1_busy !== 1'b0) begin errors++; $display("FAIL mid_rst1: got v=%b %h busy=%b expected v=0 80000000 busy=0", r1_rsp_valid, r1_rsp_instr, r1_busy); end
    checks++; if (r2_rsp_valid !== 1'b0 || r2_rsp_instr !== 32'h8000_0000 || r2_rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rst2: got v=%b %h e=%b expected v=0 80000000 e=0", r2_rsp_valid, r2_rsp_instr, r2_rsp_err); end
    rsp_ready = 1'b1;
    reset = 1'b1;
    tick;
    checks++; if (r1_req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", r1_req_ready); end
    req_valid = 1'b1; req_addr = 32'hC;
    tick;
    req_valid = 1'b0;
    checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_instr !== words[3]) begin errors++; $display("FAIL retain1: got v=%b %h expected v=1 %h", r1_rsp_valid, r1_rsp_instr, words[3]); end
    tick;
    checks++; if (r2_rsp_valid !== 1'b1 || r2_rsp_instr !== words[3]) begin errors++; $display("FAIL retain2: got v=%b %h expected v=1 %h", r2_rsp_valid, r2_rsp_instr, words[3]); end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    words[0] = 32'h0800_0003;
    words[1] = 32'h2008_0014;
    words[2] = 32'h0100_0008;
    words[3] = 32'h3c08_4000;
    test_reset;
    test_load_program;
    test_fetch_lat1;
    test_errors;
    test_backpressure;
    test_drain_load;
    test_we_in_run;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
